// File: rtl/rv_csr_trap.sv
// Machine-mode CSR file and trap controller for the rv32i core family.
// Holds the M-mode CSRs and the cycle/instret counters, and handles
// exception and interrupt entry and MRET. Each accepted event produces a
// one-cycle registered PC redirect for the core.
module rv_csr_trap #(
    parameter int          CNT_WIDTH   = 64,
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MIMPID      = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    input  logic        csr_we,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        retire,
    input  logic        trap_req,
    input  logic [4:0]  trap_cause,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_tval,
    input  logic        irq_take,
    input  logic        mret,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic        irq_ext,
    output logic        irq_pending,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    // mtvec[1] is always 0; mtvec[0] survives only when vectored mode exists
    localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

    logic                 r_mst_mie;
    logic                 r_mst_mpie;
    logic [31:0]          r_mie;
    logic [31:0]          r_mtvec;
    logic [31:0]          r_mscratch;
    logic [31:0]          r_mepc;
    logic [31:0]          r_mcause;
    logic [31:0]          r_mtval;
    logic [CNT_WIDTH-1:0] r_mcycle;
    logic [CNT_WIDTH-1:0] r_minstret;
    logic                 r_redirect;
    logic [31:0]          r_redirect_pc;

    logic [63:0] w_mcycle64;
    logic [63:0] w_minstret64;
    logic [63:0] w_cyc_nxt;
    logic [63:0] w_ins_nxt;
    logic [31:0] w_mip;
    logic [31:0] w_irq_act;
    logic [31:0] w_rdata;
    logic [31:0] w_wval;
    logic [31:0] w_mtvec_base;
    logic [31:0] w_vec_off;
    logic [4:0]  w_irq_code;
    logic        w_impl;
    logic        w_ro;
    logic        w_illegal;
    logic        w_irq_pend;
    logic        w_irq_acc;
    logic        w_csr_wr;

    assign w_mcycle64   = 64'(r_mcycle);
    assign w_minstret64 = 64'(r_minstret);
    assign w_mip        = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
    assign w_irq_act    = w_mip & r_mie;
    assign w_irq_pend   = r_mst_mie & (|w_irq_act);
    assign w_irq_acc    = irq_take & w_irq_pend;
    assign w_mtvec_base = {r_mtvec[31:2], 2'b00};
    assign w_vec_off    = r_mtvec[0] ? {25'b0, w_irq_code, 2'b00} : 32'h0;

    // Lower-priority events in a cycle with a trap, interrupt or MRET are dropped
    assign w_csr_wr = csr_we && (csr_op != 2'b00) && !w_illegal
                      && !trap_req && !w_irq_acc && !mret;

    // Interrupt cause: external beats software beats timer
    always_comb begin
        if (w_irq_act[11])     w_irq_code = 5'd11;
        else if (w_irq_act[3]) w_irq_code = 5'd3;
        else                   w_irq_code = 5'd7;
    end

    // Read mux plus implemented / read-only decode of csr_addr
    always_comb begin
        w_rdata = 32'h0;
        w_impl  = 1'b1;
        w_ro    = 1'b0;
        case (csr_addr)
            12'h300: w_rdata = {19'b0, 2'b11, 3'b0, r_mst_mpie, 3'b0, r_mst_mie, 3'b0};
            12'h304: w_rdata = r_mie;
            12'h305: w_rdata = r_mtvec;
            12'h340: w_rdata = r_mscratch;
            12'h341: w_rdata = r_mepc;
            12'h342: w_rdata = r_mcause;
            12'h343: w_rdata = r_mtval;
            12'hB00: w_rdata = w_mcycle64[31:0];
            12'hB80: w_rdata = w_mcycle64[63:32];
            12'hB02: w_rdata = w_minstret64[31:0];
            12'hB82: w_rdata = w_minstret64[63:32];
            12'h301: begin w_rdata = 32'h4000_0100;       w_ro = 1'b1; end
            12'hF11: begin w_rdata = 32'h0;               w_ro = 1'b1; end
            12'hF12: begin w_rdata = 32'h0;               w_ro = 1'b1; end
            12'hF13: begin w_rdata = MIMPID;              w_ro = 1'b1; end
            12'hF14: begin w_rdata = HART_ID;             w_ro = 1'b1; end
            12'h344: begin w_rdata = w_mip;               w_ro = 1'b1; end
            12'hC00: begin w_rdata = w_mcycle64[31:0];    w_ro = 1'b1; end
            12'hC80: begin w_rdata = w_mcycle64[63:32];   w_ro = 1'b1; end
            12'hC01: begin w_rdata = w_mcycle64[31:0];    w_ro = 1'b1; end
            12'hC81: begin w_rdata = w_mcycle64[63:32];   w_ro = 1'b1; end
            12'hC02: begin w_rdata = w_minstret64[31:0];  w_ro = 1'b1; end
            12'hC82: begin w_rdata = w_minstret64[63:32]; w_ro = 1'b1; end
            default: w_impl = 1'b0;
        endcase
    end

    assign w_illegal = (csr_op != 2'b00) && (!w_impl || (w_ro && csr_we));

    // New CSR value from the op applied to the pre-write value
    always_comb begin
        case (csr_op)
            2'b01:   w_wval = csr_wdata;
            2'b10:   w_wval = w_rdata | csr_wdata;
            2'b11:   w_wval = w_rdata & ~csr_wdata;
            default: w_wval = w_rdata;
        endcase
    end

    // Counter next values; a write to either half replaces the increment
    always_comb begin
        w_cyc_nxt = w_mcycle64 + 64'd1;
        w_ins_nxt = w_minstret64 + {63'd0, retire};
        if (w_csr_wr) begin
            case (csr_addr)
                12'hB00: w_cyc_nxt = {w_mcycle64[63:32], w_wval};
                12'hB80: w_cyc_nxt = {w_wval, w_mcycle64[31:0]};
                12'hB02: w_ins_nxt = {w_minstret64[63:32], w_wval};
                12'hB82: w_ins_nxt = {w_wval, w_minstret64[31:0]};
                default: ;
            endcase
        end
    end

    // Counter registers, truncated to CNT_WIDTH so they wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            r_mcycle   <= w_cyc_nxt[CNT_WIDTH-1:0];
            r_minstret <= w_ins_nxt[CNT_WIDTH-1:0];
        end
    end

    // Trap / interrupt / MRET / CSR-write state updates in priority order
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mst_mie  <= 1'b0;
            r_mst_mpie <= 1'b0;
            r_mie      <= 32'h0;
            r_mtvec    <= MTVEC_RESET & MTVEC_MASK;
            r_mscratch <= 32'h0;
            r_mepc     <= 32'h0;
            r_mcause   <= 32'h0;
            r_mtval    <= 32'h0;
        end else if (trap_req) begin
            r_mepc     <= trap_epc & 32'hFFFF_FFFC;
            r_mcause   <= {27'b0, trap_cause};
            r_mtval    <= trap_tval;
            r_mst_mpie <= r_mst_mie;
            r_mst_mie  <= 1'b0;
        end else if (w_irq_acc) begin
            r_mepc     <= trap_epc & 32'hFFFF_FFFC;
            r_mcause   <= {1'b1, 26'b0, w_irq_code};
            r_mtval    <= 32'h0;
            r_mst_mpie <= r_mst_mie;
            r_mst_mie  <= 1'b0;
        end else if (mret) begin
            r_mst_mie  <= r_mst_mpie;
            r_mst_mpie <= 1'b1;
        end else if (w_csr_wr) begin
            case (csr_addr)
                12'h300: begin
                    r_mst_mie  <= w_wval[3];
                    r_mst_mpie <= w_wval[7];
                end
                12'h304: r_mie      <= w_wval & MIE_MASK;
                12'h305: r_mtvec    <= w_wval & MTVEC_MASK;
                12'h340: r_mscratch <= w_wval;
                12'h341: r_mepc     <= w_wval & 32'hFFFF_FFFC;
                12'h342: r_mcause   <= w_wval;
                12'h343: r_mtval    <= w_wval;
                default: ;
            endcase
        end
    end

    // One-cycle redirect pulse with its target, registered for the core
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'h0;
        end else if (trap_req) begin
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_mtvec_base;
        end else if (w_irq_acc) begin
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_mtvec_base + w_vec_off;
        end else if (mret) begin
            r_redirect    <= 1'b1;
            r_redirect_pc <= r_mepc;
        end else begin
            r_redirect    <= 1'b0;
        end
    end

    assign csr_rdata   = w_rdata;
    assign csr_illegal = w_illegal;
    assign irq_pending = w_irq_pend;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_rv_csr_trap.sv
// Bench for rv_csr_trap: two instances (64-bit vectored, 32-bit direct)
// share one stimulus stream and are compared every cycle with a CSR-level
// model, plus a reset-read table and directed trap/irq/counter sequences.
module tb_rv_csr_trap;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic        retire;
    logic        trap_req;
    logic [4:0]  trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        irq_take;
    logic        mret;
    logic        irq_sw, irq_timer, irq_ext;

    logic [31:0] rdata [2];
    logic        ill   [2];
    logic        pend  [2];
    logic        redir [2];
    logic [31:0] rpc   [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_csr_trap #(.CNT_WIDTH(64), .HART_ID(32'h0), .MIMPID(32'h0),
                  .MTVEC_RESET(32'h0), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_rdata(rdata[0]),
        .csr_illegal(ill[0]), .retire(retire), .trap_req(trap_req),
        .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
        .irq_take(irq_take), .mret(mret), .irq_sw(irq_sw),
        .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_pending(pend[0]),
        .redirect(redir[0]), .redirect_pc(rpc[0]));

    rv_csr_trap #(.CNT_WIDTH(32), .HART_ID(32'h5), .MIMPID(32'h7),
                  .MTVEC_RESET(32'h203), .VECTORED_EN(1'b0)) dut32 (
        .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_rdata(rdata[1]),
        .csr_illegal(ill[1]), .retire(retire), .trap_req(trap_req),
        .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
        .irq_take(irq_take), .mret(mret), .irq_sw(irq_sw),
        .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_pending(pend[1]),
        .redirect(redir[1]), .redirect_pc(rpc[1]));

    // ---------------- reference model ----------------
    int          cfg_cw   [2] = '{64, 32};
    bit          cfg_vec  [2] = '{1'b1, 1'b0};
    logic [31:0] cfg_hart [2] = '{32'h0, 32'h5};
    logic [31:0] cfg_imp  [2] = '{32'h0, 32'h7};
    logic [31:0] cfg_tvec [2] = '{32'h0, 32'h203};

    bit          m_sie [2], m_mpie [2], m_redir [2];
    logic [31:0] m_mie [2], m_mtvec [2], m_scr [2], m_mepc [2];
    logic [31:0] m_mcause [2], m_mtval [2], m_rpc [2];
    logic [63:0] m_cyc [2], m_ins [2];

    function automatic logic [63:0] cmask(input int k);
        return (cfg_cw[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << cfg_cw[k]) - 64'd1);
    endfunction

    function automatic logic [31:0] tvec_mask(input int k);
        return cfg_vec[k] ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] mip_now();
        return 32'(irq_sw) * 8 + 32'(irq_timer) * 128 + 32'(irq_ext) * 2048;
    endfunction

    function automatic bit m_pending(input int k);
        return m_sie[k] && ((mip_now() & m_mie[k]) != 0);
    endfunction

    function automatic void mread(input int k, input logic [11:0] a,
                                  output logic [31:0] v, output bit impl, output bit ro);
        logic [63:0] c = m_cyc[k];
        logic [63:0] n = m_ins[k];
        v = 0; impl = 1; ro = 0;
        case (a)
            12'h300: v = 32'h1800 + (m_mpie[k] ? 32'h80 : 0) + (m_sie[k] ? 32'h8 : 0);
            12'h304: v = m_mie[k];
            12'h305: v = m_mtvec[k];
            12'h340: v = m_scr[k];
            12'h341: v = m_mepc[k];
            12'h342: v = m_mcause[k];
            12'h343: v = m_mtval[k];
            12'hB00: v = c[31:0];
            12'hB80: v = c[63:32];
            12'hB02: v = n[31:0];
            12'hB82: v = n[63:32];
            12'h301: begin v = 32'h4000_0100; ro = 1; end
            12'hF11, 12'hF12: ro = 1;
            12'hF13: begin v = cfg_imp[k];  ro = 1; end
            12'hF14: begin v = cfg_hart[k]; ro = 1; end
            12'h344: begin v = mip_now();   ro = 1; end
            12'hC00, 12'hC01: begin v = c[31:0];  ro = 1; end
            12'hC80, 12'hC81: begin v = c[63:32]; ro = 1; end
            12'hC02: begin v = n[31:0];  ro = 1; end
            12'hC82: begin v = n[63:32]; ro = 1; end
            default: impl = 0;
        endcase
    endfunction

    function automatic bit m_illegal(input int k);
        logic [31:0] v; bit impl, ro;
        mread(k, csr_addr, v, impl, ro);
        return (csr_op != 0) && (!impl || (ro && csr_we));
    endfunction

    // state change of one model instance at a clock edge
    function automatic void mupdate(input int k);
        logic [31:0] old, wv, code, base;
        bit impl, ro, pnd, bad;
        logic [63:0] c, n;
        mread(k, csr_addr, old, impl, ro);
        pnd = m_pending(k);
        bad = m_illegal(k);
        c = m_cyc[k] + 1;
        n = m_ins[k] + (retire ? 1 : 0);
        base = m_mtvec[k] & 32'hFFFF_FFFC;
        m_redir[k] = 0;
        if (rst) begin
            m_sie[k] = 0; m_mpie[k] = 0; m_mie[k] = 0; m_scr[k] = 0;
            m_mepc[k] = 0; m_mcause[k] = 0; m_mtval[k] = 0;
            m_mtvec[k] = cfg_tvec[k] & tvec_mask(k);
            m_rpc[k] = 0; m_cyc[k] = 0; m_ins[k] = 0;
            return;
        end
        if (trap_req) begin
            m_mepc[k] = trap_epc & ~32'd3; m_mcause[k] = 32'(trap_cause);
            m_mtval[k] = trap_tval; m_mpie[k] = m_sie[k]; m_sie[k] = 0;
            m_redir[k] = 1; m_rpc[k] = base;
        end else if (irq_take && pnd) begin
            if (irq_ext && m_mie[k][11])      code = 11;
            else if (irq_sw && m_mie[k][3])   code = 3;
            else                              code = 7;
            m_mepc[k] = trap_epc & ~32'd3; m_mcause[k] = 32'h8000_0000 + code;
            m_mtval[k] = 0; m_mpie[k] = m_sie[k]; m_sie[k] = 0;
            m_redir[k] = 1; m_rpc[k] = base + (m_mtvec[k][0] ? 4 * code : 0);
        end else if (mret) begin
            m_sie[k] = m_mpie[k]; m_mpie[k] = 1;
            m_redir[k] = 1; m_rpc[k] = m_mepc[k];
        end else if (csr_we && csr_op != 0 && !bad) begin
            case (csr_op)
                2'd1:    wv = csr_wdata;
                2'd2:    wv = old | csr_wdata;
                default: wv = old & ~csr_wdata;
            endcase
            case (csr_addr)
                12'h300: begin m_sie[k] = wv[3]; m_mpie[k] = wv[7]; end
                12'h304: m_mie[k] = wv & 32'h888;
                12'h305: m_mtvec[k] = wv & tvec_mask(k);
                12'h340: m_scr[k] = wv;
                12'h341: m_mepc[k] = wv & ~32'd3;
                12'h342: m_mcause[k] = wv;
                12'h343: m_mtval[k] = wv;
                12'hB00: c = (m_cyc[k] & 64'hFFFF_FFFF_0000_0000) | 64'(wv);
                12'hB80: c = (64'(wv) << 32) | (m_cyc[k] & 64'hFFFF_FFFF);
                12'hB02: n = (m_ins[k] & 64'hFFFF_FFFF_0000_0000) | 64'(wv);
                12'hB82: n = (64'(wv) << 32) | (m_ins[k] & 64'hFFFF_FFFF);
                default: ;
            endcase
        end
        m_cyc[k] = c & cmask(k);
        m_ins[k] = n & cmask(k);
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] v; bit impl, ro;
        for (int k = 0; k < 2; k++) begin
            mread(k, csr_addr, v, impl, ro);
            chk($sformatf("illegal[%0d]@%h", k, csr_addr), 32'(ill[k]), 32'(m_illegal(k)));
            if (impl) chk($sformatf("rdata[%0d]@%h", k, csr_addr), rdata[k], v);
            chk($sformatf("irq_pending[%0d]", k), 32'(pend[k]), 32'(m_pending(k)));
            chk($sformatf("redirect[%0d]", k), 32'(redir[k]), 32'(m_redir[k]));
            if (m_redir[k]) chk($sformatf("redirect_pc[%0d]", k), rpc[k], m_rpc[k]);
        end
    endtask

    task automatic settle(); #2; check_model(); endtask
    task automatic edge_(); @(posedge clk); mupdate(0); mupdate(1); #1; endtask
    task automatic run(); settle(); edge_(); endtask

    task automatic idle();
        csr_addr = 12'h340; csr_op = 0; csr_wdata = 0; csr_we = 0;
        retire = 0; trap_req = 0; trap_cause = 0; trap_epc = 0; trap_tval = 0;
        irq_take = 0; mret = 0;
    endtask

    task automatic csr(input logic [11:0] a, input logic [1:0] op,
                       input logic [31:0] wd, input logic we);
        idle(); csr_addr = a; csr_op = op; csr_wdata = wd; csr_we = we;
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic        we;
        logic [31:0] exp_rd;
        logic        exp_ill;
        bit          rd_valid;
    } vec_t;

    vec_t tbl [22];
    logic [11:0] alist [26] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h301,
                                12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h344, 12'hC00,
                                12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82, 12'h7C0,
                                12'h302, 12'hB01};

    initial begin
        tbl[0]  = '{12'h300, 2'd0, 1'b0, 32'h0000_1800, 1'b0, 1'b1};
        tbl[1]  = '{12'h301, 2'd0, 1'b0, 32'h4000_0100, 1'b0, 1'b1};
        tbl[2]  = '{12'h304, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[3]  = '{12'h305, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[4]  = '{12'h340, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[5]  = '{12'h341, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[6]  = '{12'h342, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[7]  = '{12'h343, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[8]  = '{12'hF11, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[9]  = '{12'hF12, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[10] = '{12'hF13, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[11] = '{12'hF14, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[12] = '{12'h344, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[13] = '{12'hB02, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[14] = '{12'hC82, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[15] = '{12'h301, 2'd1, 1'b1, 32'h4000_0100, 1'b1, 1'b1};
        tbl[16] = '{12'hF14, 2'd3, 1'b1, 32'h0, 1'b1, 1'b1};
        tbl[17] = '{12'h344, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[18] = '{12'h7C0, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0};
        tbl[19] = '{12'h7C0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[20] = '{12'hB80, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[21] = '{12'hC01, 2'd2, 1'b1, 32'h0, 1'b1, 1'b0};

        idle(); irq_sw = 0; irq_timer = 0; irq_ext = 0;
        for (int k = 0; k < 2; k++) begin
            m_sie[k] = 0; m_mpie[k] = 0; m_redir[k] = 0; m_mie[k] = 0; m_mtvec[k] = 0;
            m_scr[k] = 0; m_mepc[k] = 0; m_mcause[k] = 0; m_mtval[k] = 0;
            m_rpc[k] = 0; m_cyc[k] = 0; m_ins[k] = 0;
        end
        rst = 1;
        #1; edge_(); edge_();

        // reset values of redirect outputs and the vector base of both configs
        csr_addr = 12'h305;
        #2;
        chk("reset redirect", 32'(redir[0]), 32'h0);
        chk("reset redirect_pc", rpc[0], 32'h0);
        chk("reset redirect_pc32", rpc[1], 32'h0);
        chk("reset mtvec32", rdata[1], 32'h200);
        rst = 0;
        edge_();
        // mcycle counts from release
        csr_addr = 12'hB00;
        for (int i = 0; i < 4; i++) run();
        settle();
        chk("mcycle 5 after release", rdata[0], 32'd5);
        edge_();

        // reset read table (expectations are for the 64-bit vectored instance)
        foreach (tbl[i]) begin
            csr(tbl[i].addr, tbl[i].op, 32'hFFFF_FFFF, tbl[i].we);
            settle();
            chk($sformatf("tbl%0d illegal", i), 32'(ill[0]), 32'(tbl[i].exp_ill));
            if (tbl[i].rd_valid)
                chk($sformatf("tbl%0d rdata", i), rdata[0], tbl[i].exp_rd);
            edge_();
        end

        // mscratch RW / RS / RC, with pre-write value visible during the write
        csr(12'h340, 2'd1, 32'hDEADBEEF, 1); settle(); chk("rw old", rdata[0], 32'h0); edge_();
        csr(12'h340, 2'd2, 32'h0F, 1); settle(); chk("rs old", rdata[0], 32'hDEADBEEF); edge_();
        csr(12'h340, 2'd3, 32'hF0, 1); settle(); chk("rc old", rdata[0], 32'hDEADBEEF); edge_();
        csr(12'h340, 2'd0, 0, 0); settle(); chk("rc result", rdata[0], 32'hDEADBE0F); edge_();

        // synchronous trap then MRET
        csr(12'h305, 2'd1, 32'h100, 1); run();
        csr(12'h300, 2'd1, 32'h8, 1); run();
        idle(); trap_req = 1; trap_cause = 5'd11; trap_epc = 32'h204; trap_tval = 0; run();
        csr(12'h341, 2'd0, 0, 0); settle();
        chk("trap redirect", 32'(redir[0]), 32'h1);
        chk("trap redirect_pc", rpc[0], 32'h100);
        chk("trap mepc", rdata[0], 32'h204);
        edge_();
        csr(12'h342, 2'd0, 0, 0); settle(); chk("trap mcause", rdata[0], 32'd11);
        chk("redirect one cycle", 32'(redir[0]), 32'h0); edge_();
        csr(12'h300, 2'd0, 0, 0); settle(); chk("trap mstatus", rdata[0], 32'h1880); edge_();
        idle(); mret = 1; run();
        csr(12'h300, 2'd0, 0, 0); settle();
        chk("mret redirect", 32'(redir[0]), 32'h1);
        chk("mret redirect_pc", rpc[0], 32'h204);
        chk("mret mstatus", rdata[0], 32'h1888);
        edge_();

        // vectored interrupts
        csr(12'h305, 2'd1, 32'h101, 1); run();
        csr(12'h304, 2'd1, 32'h880, 1); run();
        csr(12'h300, 2'd1, 32'h8, 1); irq_timer = 1; irq_ext = 1; run();
        idle(); irq_take = 1; trap_epc = 32'h400; settle();
        chk("irq pending", 32'(pend[0]), 32'h1); edge_();
        csr(12'h342, 2'd0, 0, 0); settle();
        chk("irq ext mcause", rdata[0], 32'h8000_000B);
        chk("irq ext pc", rpc[0], 32'h12C);
        chk("irq not pending after take", 32'(pend[0]), 32'h0);
        edge_();
        csr(12'h300, 2'd1, 32'h8, 1); irq_ext = 0; run();
        idle(); irq_take = 1; run();
        csr(12'h342, 2'd0, 0, 0); settle();
        chk("irq timer mcause", rdata[0], 32'h8000_0007);
        chk("irq timer pc", rpc[0], 32'h11C);
        edge_();
        irq_timer = 0;

        // 32-bit counter wrap on the second instance, and a read-only write
        csr(12'hB00, 2'd1, 32'hFFFF_FFFE, 1); run();
        csr(12'hB00, 2'd0, 0, 0);
        settle(); chk("cnt32 fe", rdata[1], 32'hFFFF_FFFE); edge_();
        settle(); chk("cnt32 ff", rdata[1], 32'hFFFF_FFFF); edge_();
        settle(); chk("cnt32 wrap0", rdata[1], 32'h0); edge_();
        csr(12'hB80, 2'd0, 0, 0); settle();
        chk("cnt32 mcycleh", rdata[1], 32'h0);
        chk("cnt64 carry mcycleh", rdata[0], 32'h1);
        edge_();
        csr(12'hC00, 2'd1, 32'h0, 1); settle();
        chk("cycle write illegal", 32'(ill[1]), 32'h1);
        chk("cycle alias", rdata[1], 32'h2);
        edge_();
        csr(12'hB00, 2'd0, 0, 0); settle(); chk("cnt32 after illegal", rdata[1], 32'h3); edge_();

        // trap + mret + CSR write together: only the trap applies
        idle(); trap_req = 1; trap_cause = 5'd2; trap_epc = 32'h88; mret = 1;
        csr_addr = 12'h340; csr_op = 2'd1; csr_wdata = 32'h12345678; csr_we = 1; run();
        csr(12'h340, 2'd0, 0, 0); settle();
        chk("combo mscratch", rdata[0], 32'hDEADBE0F);
        chk("combo redirect", 32'(redir[0]), 32'h1);
        chk("combo redirect_pc", rpc[0], 32'h100);
        edge_();
        settle(); chk("combo single pulse", 32'(redir[0]), 32'h0); edge_();

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            idle();
            csr_addr   = alist[$urandom_range(0, 25)];
            csr_op     = 2'($urandom_range(0, 3));
            csr_wdata  = $urandom;
            csr_we     = ($urandom_range(0, 9) < 4);
            retire     = $urandom_range(0, 1) == 1;
            trap_req   = ($urandom_range(0, 19) == 0);
            trap_cause = 5'($urandom);
            trap_epc   = $urandom;
            trap_tval  = $urandom;
            irq_take   = ($urandom_range(0, 9) == 0);
            mret       = ($urandom_range(0, 19) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) irq_sw    = ~irq_sw;
            if ($urandom_range(0, 3) == 0) irq_timer = ~irq_timer;
            if ($urandom_range(0, 3) == 0) irq_ext   = ~irq_ext;
            run();
        end
        rst = 0; idle(); run();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rv_csr_trap.md
Name: rv_csr_trap

Overview:
Parametrised machine-mode CSR file and trap controller for the rv32i core family. It replaces the ad-hoc CSR registers and read mux inside the core. It adds:
- trap entry (ECALL/EBREAK/illegal),
- MRET return,
- three level-sensitive interrupt sources with mstatus/mie gating,
- direct/vectored mtvec,
- counters of configurable width.

The core drives it from its execute/write-back stages and takes a registered PC redirect from it.

Parameters:
CNT_WIDTH, 64, width of the mcycle/minstret counters, legal range 32..64; counter bits above CNT_WIDTH read 0.
HART_ID, 0, value returned by mhartid.
MIMPID, 0, value returned by mimpid.
MTVEC_RESET, 32'h0, reset value of mtvec.
VECTORED_EN, 1, if 1 mtvec mode 01 (vectored) is honoured; if 0 the mode bits are hardwired to 00.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
csr_addr  in  12  CSR address of current access
csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
csr_wdata  in  32  write operand (rs1 value or zero-extended uimm)
csr_we  in  1  commit strobe for csr_op this cycle
csr_rdata  out  32  combinational read of csr_addr; shows pre-write value
csr_illegal  out  1  combinational: csr_op!=00 and (address unimplemented, or write to read-only CSR with csr_we)
retire  in  1  one instruction retired this cycle
trap_req  in  1  synchronous exception taken this cycle
trap_cause  in  5  exception code (bit31 of mcause = 0)
trap_epc  in  32  PC saved to mepc on trap_req / irq_take
trap_tval  in  32  value for mtval on trap_req
irq_take  in  1  core accepts pending interrupt at an instruction boundary
mret  in  1  MRET executed this cycle
irq_sw, irq_timer, irq_ext  in  1 each  level interrupt lines
irq_pending  out  1  combinational: mstatus.MIE & |(mip & mie)
redirect  out  1  registered one-cycle pulse: core must load redirect_pc
redirect_pc  out  32  registered target, valid when redirect=1

Behaviour:
Reset:
- mstatus.MIE=0, MPIE=0. MPP reads 2'b11 always.
- mie=0, mscratch=0, mepc=0, mcause=0, mtval=0, mcycle=0, minstret=0.
- mtvec=MTVEC_RESET, mode bits masked per VECTORED_EN.
- redirect=0, redirect_pc=0.
- Reset mid-trap cancels any pending redirect.

CSR map:
- Read-write: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle/h 0xB00/0xB80, minstret/h 0xB02/0xB82.
- Read-only: misa 0x301=32'h40000100, mvendorid 0xF11=0, marchid 0xF12=0, mimpid 0xF13, mhartid 0xF14, mip 0x344, cycle/h 0xC00/0xC80, time/h 0xC01/0xC81 (alias mcycle), instret/h 0xC02/0xC82.
- Writable field masks: mstatus bits 3,7 only. mie bits 3,7,11 only. mepc[1:0] forced 0. mtvec[1] forced 0; mtvec[0] forced 0 when VECTORED_EN=0.
- mip bits 3/7/11 = irq_sw/irq_timer/irq_ext, sampled live.
- Write value: RW=wdata, RS=old|wdata, RC=old&~wdata. Applied at the clock edge when csr_we=1 and csr_illegal=0.
- Illegal writes change nothing.

Counters:
- mcycle increments every cycle; minstret increments when retire=1.
- Both wrap modulo 2^CNT_WIDTH.
- A CSR write to either half in the same cycle wins over the increment for the whole counter. The other half keeps its pre-increment value.

Event priority per cycle: rst > trap_req > irq_take > mret > csr_we. A lower-priority event in the same cycle is dropped entirely.

trap_req:
- mepc<=trap_epc&~3, mcause<={27'b0,trap_cause}, mtval<=trap_tval.
- MPIE<=MIE, MIE<=0.
- Next cycle: redirect=1, redirect_pc={mtvec[31:2],2'b00}.

irq_take (ignored unless irq_pending=1):
- Cause selection, highest first: ext 11, sw 3, timer 7. mcause<={1'b1,26'b0,code}, mtval<=0.
- mepc and MIE/MPIE updated as for trap_req.
- redirect_pc = base + 4*code when mtvec[0]=1, else base.

mret:
- MIE<=MPIE, MPIE<=1.
- Next cycle: redirect=1, redirect_pc=mepc.

General:
- redirect is high for exactly one cycle per accepted event.
- Back-to-back events each produce their own pulse.
- CSR reads are pure: no side effects.

Test Plan:
1. Reset, then read all CSRs -> misa=32'h40000100, mtvec=MTVEC_RESET, all others 0 except MPP=11. mcycle=5 at 5 cycles after reset release.
2. RW mscratch=32'hDEADBEEF, then RS 32'h0F, then RC 32'hF0 -> reads 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBE0F. csr_rdata shows the old value in each write cycle.
3. mtvec=32'h100, trap_req with cause 11, epc 32'h204, tval 0 -> next cycle redirect=1 to 32'h100. mepc=32'h204, mcause=11, MIE=0, MPIE=old MIE. Then mret -> redirect to 32'h204, MIE restored.
4. Interrupts: mtvec=32'h101, mie=32'h880, MIE=1, irq_timer=irq_ext=1, irq_take -> mcause=32'h8000000B, redirect_pc=32'h12C. With irq_ext=0: mcause=32'h80000007, redirect_pc=32'h11C.
5. CNT_WIDTH=32: write mcycle=32'hFFFFFFFE, hold 3 cycles -> reads 0 then 1, mcycleh reads 0. Write to 0xC00 -> csr_illegal=1, counter unchanged.
6. Simultaneous trap_req+mret+csr_we to mscratch -> only the trap applies, mscratch unchanged, single redirect to mtvec base.
